// File: rtl/parking_request_sequencer.sv
// Parking request sequencer: synchronizes and debounces the gate buttons, holds
// one pending request per direction, validates against the controller's
// capacity/occupancy, and issues single-cycle requests with a door handshake.
module parking_request_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DOOR_TIMEOUT    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_btn,
  input  logic       exit_btn,
  input  logic [1:0] exit_slot_sw,
  input  logic       is_open,
  input  logic [2:0] capacity,
  input  logic [3:0] spots,
  output logic       entry_signal,
  output logic       exit_signal,
  output logic [1:0] exit_slot,
  output logic       busy,
  output logic       reject,
  output logic [1:0] pending
);

  localparam int unsigned DB_W   = 4;
  localparam int unsigned TO_W   = 8;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_OPEN, WAIT_CLOSE} state_t;

  state_t              state, state_n;
  logic                entry_s1, entry_s2, exit_s1, exit_s2;
  logic [SLOT_W-1:0]   slot_s1, slot_s2, slot_q, slot_q_n;
  logic                entry_deb, entry_deb_n, exit_deb, exit_deb_n;
  logic [DB_W-1:0]     entry_cnt, entry_cnt_n, exit_cnt, exit_cnt_n;
  logic                entry_rise, exit_rise;
  logic                entry_pend, entry_pend_n, exit_pend, exit_pend_n;
  logic                clr_entry, clr_exit;
  logic [TO_W-1:0]     tcnt, tcnt_n;
  logic                entry_sig_n, exit_sig_n, reject_n;
  logic [SLOT_W-1:0]   exit_slot_n;

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    entry_deb_n = entry_deb;
    entry_cnt_n = '0;
    exit_deb_n  = exit_deb;
    exit_cnt_n  = '0;
    if (entry_s2 != entry_deb) begin
      if (entry_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) entry_deb_n = ~entry_deb;
      else                                          entry_cnt_n = entry_cnt + DB_W'(1);
    end
    if (exit_s2 != exit_deb) begin
      if (exit_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) exit_deb_n = ~exit_deb;
      else                                         exit_cnt_n = exit_cnt + DB_W'(1);
    end
    entry_rise = ~entry_deb & entry_deb_n;
    exit_rise  = ~exit_deb & exit_deb_n;
  end

  // Next-state, validation and output decode for the request sequencer
  always_comb begin
    state_n     = state;
    tcnt_n      = tcnt;
    entry_sig_n = 1'b0;
    exit_sig_n  = 1'b0;
    exit_slot_n = '0;
    reject_n    = 1'b0;
    clr_entry   = 1'b0;
    clr_exit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (exit_pend) begin
          clr_exit = 1'b1;
          if (spots[slot_q]) begin
            state_n     = ISSUE;
            exit_sig_n  = 1'b1;
            exit_slot_n = slot_q;
          end else begin
            reject_n = 1'b1;
          end
        end else if (entry_pend) begin
          clr_entry = 1'b1;
          if (capacity == 3'd0) begin
            reject_n = 1'b1;
          end else begin
            state_n     = ISSUE;
            entry_sig_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT_OPEN;
        tcnt_n  = '0;
      end
      WAIT_OPEN: begin
        if (is_open) begin
          state_n = WAIT_CLOSE;
        end else if (tcnt == TO_W'(DOOR_TIMEOUT - 1)) begin
          state_n  = IDLE;
          reject_n = 1'b1;
        end else begin
          tcnt_n = tcnt + TO_W'(1);
        end
      end
      WAIT_CLOSE: begin
        if (!is_open) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pending flags: one deep; a new press is taken only when the flag is (being) free
  always_comb begin
    entry_pend_n = entry_pend & ~clr_entry;
    exit_pend_n  = exit_pend & ~clr_exit;
    slot_q_n     = slot_q;
    if (entry_rise && !entry_pend_n) entry_pend_n = 1'b1;
    if (exit_rise && !exit_pend_n) begin
      exit_pend_n = 1'b1;
      slot_q_n    = slot_s2;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      entry_s1     <= 1'b0;
      entry_s2     <= 1'b0;
      exit_s1      <= 1'b0;
      exit_s2      <= 1'b0;
      slot_s1      <= '0;
      slot_s2      <= '0;
      slot_q       <= '0;
      entry_deb    <= 1'b0;
      exit_deb     <= 1'b0;
      entry_cnt    <= '0;
      exit_cnt     <= '0;
      entry_pend   <= 1'b0;
      exit_pend    <= 1'b0;
      tcnt         <= '0;
      entry_signal <= 1'b0;
      exit_signal  <= 1'b0;
      exit_slot    <= '0;
      reject       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      entry_s1     <= entry_btn;
      entry_s2     <= entry_s1;
      exit_s1      <= exit_btn;
      exit_s2      <= exit_s1;
      slot_s1      <= exit_slot_sw;
      slot_s2      <= slot_s1;
      slot_q       <= slot_q_n;
      entry_deb    <= entry_deb_n;
      exit_deb     <= exit_deb_n;
      entry_cnt    <= entry_cnt_n;
      exit_cnt     <= exit_cnt_n;
      entry_pend   <= entry_pend_n;
      exit_pend    <= exit_pend_n;
      tcnt         <= tcnt_n;
      entry_signal <= entry_sig_n;
      exit_signal  <= exit_sig_n;
      exit_slot    <= exit_slot_n;
      reject       <= reject_n;
      busy         <= (state_n != IDLE);
    end
  end

  assign pending = {exit_pend, entry_pend};

endmodule
